// File: rtl/sigmf_rr_sched_pkg.sv
// rtl/sigmf_rr_sched_pkg.sv - Q8.16 constants, width helper and the sigmf datapath function
package sigmf_rr_sched_pkg;

  localparam int Q_WIDTH = 24;
  localparam logic [Q_WIDTH-1:0] ONE  = 24'h010000;
  localparam logic [Q_WIDTH-1:0] HALF = 24'h008000;

  // Tag width for n requesters; never below one bit so a single lane still has a tag.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Piecewise-linear sigmoid on Q8.16, evaluated on |x| and mirrored as 1 - s(|x|):
  //   |x| < 0.5      : 0.5   + |x|/4
  //   0.5 <= |x| < 2 : 0.625 + (|x|-0.5)*0.2   (0.2 as 13107/65536, truncated)
  //   |x| >= 2       : 0.925 + (|x|-2)/32, clamped to 1.0
  function automatic logic [Q_WIDTH-1:0] sigmf(input logic [Q_WIDTH-1:0] x);
    logic [Q_WIDTH:0]   ax;
    logic [Q_WIDTH-1:0] y;
    logic [31:0]        prod;
    prod = '0;
    ax = x[Q_WIDTH-1] ? (~{x[Q_WIDTH-1], x} + 25'd1) : {1'b0, x};
    if (ax < 25'h008000) begin
      y = HALF + 24'(ax >> 2);
    end else if (ax < 25'h020000) begin
      prod = 32'(ax - 25'h008000) * 32'd13107;
      y = 24'h00A000 + 24'(prod >> 16);
    end else begin
      y = 24'h00ECCC + 24'((ax - 25'h020000) >> 5);
      if (y > ONE) y = ONE;
    end
    if (x[Q_WIDTH-1]) y = ONE - y;
    return y;
  endfunction

endpackage

// File: rtl/sigmf_rr_sched_if.sv
// rtl/sigmf_rr_sched_if.sv - request/result handshake bundle of the sigmf scheduler
interface sigmf_rr_sched_if
  import sigmf_rr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = Q_WIDTH,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;
  logic                  busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/sigmf_rr_sched_rr_arb.sv
// rtl/sigmf_rr_sched_rr_arb.sv - rotating-priority arbiter, lane ptr has highest priority
module rr_arb
  import sigmf_rr_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  // Scan from ptr upward with wrap; the first requesting lane wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sigmf_rr_sched.sv
// rtl/sigmf_rr_sched.sv - round-robin share of one sigmf unit, two-stage pipe with backpressure
module sigmf_rr_sched
  import sigmf_rr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = Q_WIDTH,
  parameter int IDW   = clog2_min1(NREQ)
) (
  input logic             clk,
  input logic             rst,
  sigmf_rr_sched_if.slave bus
);

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gidx;
  logic             any;
  logic [IDW-1:0]   ptr;
  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] gdata;
  logic             adv1;
  logic             adv2;
  logic             xfer;

  rr_arb #(.N(NREQ), .IW(IDW)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  // S2 moves when empty or drained; S1 moves when empty or S2 moves.
  assign adv2 = !bus.out_valid || bus.out_ready;
  assign adv1 = !s1_v || adv2;

  // No accept while reset is held, so nothing is lost across a reset.
  assign xfer          = any && adv1 && !rst;
  assign bus.req_ready = xfer ? gnt : '0;
  assign gdata         = bus.req_data[int'(gidx)*WIDTH +: WIDTH];
  assign bus.busy      = s1_v || bus.out_valid;

  // Operand stage and round-robin pointer; pointer advances past the granted lane only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_id   <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      s1_v    <= 1'b1;
      s1_data <= gdata;
      s1_id   <= gidx;
      ptr     <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end else if (adv1) begin
      s1_v <= 1'b0;
    end
  end

  // Result stage; holds while the consumer stalls so out_* stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else if (adv2) begin
      bus.out_valid <= s1_v;
      bus.out_data  <= sigmf(s1_data);
      bus.out_id    <= s1_id;
    end
  end

endmodule

// File: tb/tb_sigmf_rr_sched.sv
// tb/tb_sigmf_rr_sched.sv - directed and randomized self-checking bench for sigmf_rr_sched
module tb_sigmf_rr_sched;
  import sigmf_rr_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int IW = 2;

  typedef struct {
    logic [W-1:0]  d;
    logic [IW-1:0] id;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sigmf_rr_sched_if #(.NREQ(N), .WIDTH(W), .IDW(IW)) bus ();

  sigmf_rr_sched #(.NREQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  item_t       q[$];
  bit          head_out;
  int          ptr_m;
  logic [W-1:0] dat[N];
  logic [N-1:0] vld;
  logic [N-1:0] acc_mask;
  logic [N-1:0] prev_g;
  logic [N-1:0] cur_g;
  logic [W-1:0] hold_d;
  logic [IW-1:0] hold_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sigmoid breakpoints and slopes in plain integer units of 2^-16.
  function automatic logic [W-1:0] ref_sigmf(input logic [W-1:0] x);
    int v;
    int a;
    int y;
    v = int'($signed(x));
    a = (v < 0) ? -v : v;
    if (a < 32768)       y = 32768 + a / 4;
    else if (a < 131072) y = 40960 + ((a - 32768) * 13107) / 65536;
    else begin
      y = 60620 + (a - 131072) / 32;
      if (y > 65536) y = 65536;
    end
    if (v < 0) y = 65536 - y;
    return W'(y);
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    if (r[1:0] == 2'd0) return r[31:8];
    return W'($urandom_range(0, 32'h0C0000)) - 24'h060000;
  endfunction

  task automatic drive();
    bus.req_valid = vld;
    for (int k = 0; k < N; k++) bus.req_data[k*W +: W] = dat[k];
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
  task automatic cyc();
    int g;
    int k;
    logic [N-1:0] exp_rdy;
    bit s1_occ;
    bit adv1;
    bit adv2;
    item_t it;
    drive();
    #3;
    s1_occ = (int'(q.size()) - int'(head_out)) > 0;
    adv2   = !head_out || bus.out_ready;
    adv1   = !s1_occ || adv2;
    g = -1;
    for (int i = 0; i < N; i++) begin
      k = (ptr_m + i) % N;
      if (g < 0 && vld[k]) g = k;
    end
    exp_rdy = '0;
    if (!rst && adv1 && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("out_valid", bus.out_valid, head_out);
    chk("busy", bus.busy, q.size() > 0);
    if (head_out) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_id", bus.out_id, q[0].id);
    end
    @(posedge clk);
    acc_mask = exp_rdy & vld;
    if (rst) begin
      q.delete();
      head_out = 0;
      ptr_m = 0;
    end else begin
      if (adv2) begin
        if (head_out) begin
          void'(q.pop_front());
          head_out = 0;
        end
        if (q.size() > 0) head_out = 1;
      end
      if (acc_mask != '0) begin
        it.d  = ref_sigmf(dat[g]);
        it.id = IW'(g);
        q.push_back(it);
        ptr_m = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic single(input int lane, input logic [W-1:0] d, input logic [W-1:0] e);
    vld = '0;
    vld[lane] = 1'b1;
    dat[lane] = d;
    cyc();
    vld = '0;
    cyc();
    #1;
    chk("single_valid", bus.out_valid, 1);
    chk("single_data", bus.out_data, e);
    chk("single_id", bus.out_id, lane);
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    vld = '1;
    for (int k = 0; k < N; k++) dat[k] = '0;
    bus.out_ready = 1'b1;
    head_out = 0;
    ptr_m = 0;
    acc_mask = '0;
    drive();
    @(posedge clk);
    #1;

    // reset held with every lane requesting
    cyc();
    cyc();
    rst = 1'b0;
    drive();
    #1;
    chk("first_grant", bus.req_ready, 4'b0001);
    cyc();
    vld = '0;
    repeat (3) cyc();

    // single operations and values
    single(2, 24'h000000, 24'h008000);
    single(1, 24'h004000, 24'h009000);
    single(3, 24'h010000, 24'h00B999);
    single(0, 24'hFF0000, 24'h004667);

    // round robin with all lanes valid
    vld = '1;
    for (int k = 0; k < N; k++) dat[k] = rnd_data();
    prev_g = '0;
    for (int i = 0; i < 12; i++) begin
      drive();
      #1;
      cur_g = bus.req_ready;
      if (i > 0) chk("rr_rotate", cur_g, {prev_g[N-2:0], prev_g[N-1]});
      prev_g = cur_g;
      cyc();
      for (int k = 0; k < N; k++) if (acc_mask[k]) dat[k] = rnd_data();
    end

    // backpressure on a full pipe
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive();
      #1;
      if (i == 0) begin
        hold_d  = bus.out_data;
        hold_id = bus.out_id;
      end else begin
        chk("bp_data_stable", bus.out_data, hold_d);
        chk("bp_id_stable", bus.out_id, hold_id);
      end
      chk("bp_ready_low", bus.req_ready, 0);
      cyc();
    end
    bus.out_ready = 1'b1;
    repeat (6) begin
      cyc();
      for (int k = 0; k < N; k++) if (acc_mask[k]) dat[k] = rnd_data();
    end
    vld = '0;
    repeat (4) cyc();

    // reset with both stages occupied
    vld = '1;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ptr_lane0", bus.req_ready, 4'b0001);
    vld = '0;
    repeat (4) cyc();

    // randomized traffic under the hold-while-pending contract
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!vld[k] || acc_mask[k]) begin
          vld[k] = ($urandom % 100) < 65;
          dat[k] = rnd_data();
        end
      end
      bus.out_ready = ($urandom % 4) != 0;
      rst = ($urandom % 150) == 0;
      cyc();
    end
    rst = 1'b0;
    vld = '0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    chk("drained", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
